// File: rtl/dispatch_ctrl.sv
// Dispatch controller: packs incoming hypervector words into four per-core operand
// slots and sequences the update / fin / stream pulses that close each item set.
module dispatch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_v,
    input  logic [31:0] src_d,
    input  logic        src_last,
    output logic        src_ready,
    output logic [31:0] core_data_1,
    output logic [31:0] core_data_2,
    output logic [31:0] core_data_3,
    output logic [31:0] core_data_4,
    output logic        update,
    output logic        last_update,
    output logic [4:0]  remainder,
    output logic        tmp_even,
    output logic [31:0] tmp_rand,
    output logic        get_fin,
    output logic        stream_v
);

    // state | meaning
    // FILL  | accepting words into slot cnt
    // ISSUE | one-cycle update pulse, slots stable
    // FIN   | one-cycle get_fin pulse after the final batch
    // OUT   | one-cycle stream_v pulse, set counters cleared
    typedef enum logic [1:0] {FILL, ISSUE, FIN, OUT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [31:0] slots [4];
    logic        last_q;
    logic [1:0]  rem_q;
    logic [15:0] total;
    logic        tmp_even_q;
    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;
    logic        accept;

    assign accept      = src_v & src_ready;
    assign core_data_1 = slots[0];
    assign core_data_2 = slots[1];
    assign core_data_3 = slots[2];
    assign core_data_4 = slots[3];
    assign tmp_rand    = lfsr;

    always_comb begin
        state_nxt   = state;
        src_ready   = 1'b0;
        update      = 1'b0;
        last_update = 1'b0;
        get_fin     = 1'b0;
        stream_v    = 1'b0;
        case (state)
            FILL: begin
                src_ready = 1'b1;
                if (accept && ((cnt == 2'd3) || src_last))
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                update      = 1'b1;
                last_update = last_q;
                state_nxt   = last_q ? FIN : FILL;
            end
            FIN: begin
                get_fin   = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                stream_v  = 1'b1;
                state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        remainder = last_update ? {3'b000, rem_q} : 5'd0;
        tmp_even  = last_update ? ~total[0] : tmp_even_q;
        lfsr_nxt  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        // The feedback map is invertible, so zero is unreachable; the guard is defensive.
        if (lfsr_nxt == 32'h0)
            lfsr_nxt = 32'h1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= 2'd0;
            last_q     <= 1'b0;
            rem_q      <= 2'd0;
            total      <= 16'd0;
            tmp_even_q <= 1'b0;
            lfsr       <= 32'h0000_0001;
            for (int i = 0; i < 4; i++)
                slots[i] <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= cnt + 2'd1;
                if (total != 16'hFFFF)
                    total <= total + 16'd1;
                // A set closing early zeroes the slots its final batch did not reach.
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == cnt)
                        slots[i] <= src_d;
                    else if (src_last && (i > int'(cnt)))
                        slots[i] <= 32'h0;
                end
                if (src_last) begin
                    last_q <= 1'b1;
                    rem_q  <= cnt + 2'd1;
                end
            end
            if (state == ISSUE) begin
                cnt    <= 2'd0;
                lfsr   <= lfsr_nxt;
                last_q <= 1'b0;
                if (last_q)
                    tmp_even_q <= ~total[0];
            end
            if (state == OUT)
                total <= 16'd0;
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: directed word sequences push hand-computed
// batch expectations; a negedge monitor pops and checks them on every update pulse.
module tb_dispatch_ctrl;

    logic        clk;
    logic        rst;
    logic        src_v;
    logic [31:0] src_d;
    logic        src_last;
    logic        src_ready;
    logic [31:0] core_data_1;
    logic [31:0] core_data_2;
    logic [31:0] core_data_3;
    logic [31:0] core_data_4;
    logic        update;
    logic        last_update;
    logic [4:0]  remainder;
    logic        tmp_even;
    logic [31:0] tmp_rand;
    logic        get_fin;
    logic        stream_v;

    dispatch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .src_v       (src_v),
        .src_d       (src_d),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .core_data_1 (core_data_1),
        .core_data_2 (core_data_2),
        .core_data_3 (core_data_3),
        .core_data_4 (core_data_4),
        .update      (update),
        .last_update (last_update),
        .remainder   (remainder),
        .tmp_even    (tmp_even),
        .tmp_rand    (tmp_rand),
        .get_fin     (get_fin),
        .stream_v    (stream_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [31:0] d4;
        bit          last;
        logic [4:0]  rem;
        bit          even;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rand = 32'h1;
    int          fin_phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

    function automatic void push(input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] d3, input logic [31:0] d4,
                                 input bit last, input logic [4:0] rem, input bit even);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.d3 = d3; e.d4 = d4;
        e.last = last; e.rem = rem; e.even = even;
        exp_q.push_back(e);
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [31:0] d, input bit last);
        int n;
        n = 0;
        src_v    = 1'b1;
        src_d    = d;
        src_last = last;
        while (!src_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("send_timeout", {31'b0, src_ready}, 32'h1);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        src_v    = 1'b0;
        src_last = 1'b0;
    endtask

    task automatic wait_stream();
        int n;
        n = 0;
        while (!stream_v && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30)
            chk("stream_timeout", {31'b0, stream_v}, 32'h1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fin_phase = 0;
        end else begin
            if (fin_phase == 1) begin
                chk("get_fin_after_last", {31'b0, get_fin}, 32'h1);
                fin_phase = 2;
            end else if (fin_phase == 2) begin
                chk("stream_v_after_fin", {31'b0, stream_v}, 32'h1);
                fin_phase = 0;
            end else begin
                if (get_fin)  chk("spurious_get_fin", {31'b0, get_fin}, 32'h0);
                if (stream_v) chk("spurious_stream_v", {31'b0, stream_v}, 32'h0);
            end
            if (update || get_fin || stream_v)
                chk("ready_low_when_busy", {31'b0, src_ready}, 32'h0);
            if (update) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_update", {31'b0, update}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("core_data_1", core_data_1, e.d1);
                    chk("core_data_2", core_data_2, e.d2);
                    chk("core_data_3", core_data_3, e.d3);
                    chk("core_data_4", core_data_4, e.d4);
                    chk("last_update", {31'b0, last_update}, {31'b0, e.last});
                    chk("remainder", {27'b0, remainder}, e.last ? {27'b0, e.rem} : 32'h0);
                    if (e.last) begin
                        chk("tmp_even", {31'b0, tmp_even}, {31'b0, e.even});
                        fin_phase = 1;
                    end
                    chk("tmp_rand", tmp_rand, exp_rand);
                    exp_rand = lfsr_next(exp_rand);
                end
            end else if (last_update) begin
                chk("last_update_without_update", {31'b0, last_update}, 32'h0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        src_v    = 1'b0;
        src_d    = 32'h0;
        src_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_src_ready", {31'b0, src_ready}, 32'h1);
        chk("rst_update", {31'b0, update}, 32'h0);
        chk("rst_core_data_1", core_data_1, 32'h0);
        chk("rst_core_data_4", core_data_4, 32'h0);
        chk("rst_remainder", {27'b0, remainder}, 32'h0);
        chk("rst_tmp_even", {31'b0, tmp_even}, 32'h0);
        chk("rst_tmp_rand", tmp_rand, 32'h1);

        // eight words, last on the eighth: two full batches
        push(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0);
        push(32'd5, 32'd6, 32'd7, 32'd8, 1'b1, 5'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), i == 8);
            if (i == 4) begin
                chk("issue_latency", {31'b0, update}, 32'h1);
                chk("tmp_rand_first", tmp_rand, 32'h1);
            end
            if (i == 5)
                chk("tmp_rand_after_1", tmp_rand, 32'h3);
        end
        idle();
        wait_stream();
        chk("tmp_rand_after_2", tmp_rand, 32'h6);

        // six words, last on the sixth: partial final batch clears slots 3/4
        push(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0);
        push(32'd5, 32'd6, 32'd0, 32'd0, 1'b1, 5'd2, 1'b1);
        for (int i = 1; i <= 6; i++)
            send(32'(i), i == 6);
        idle();
        wait_stream();
        chk("tmp_even_held", {31'b0, tmp_even}, 32'h1);

        // single word with last
        push(32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
        send(32'hA5A5A5A5, 1'b1);
        idle();
        wait_stream();
        chk("tmp_even_held_odd", {31'b0, tmp_even}, 32'h0);

        // src_v held high across ISSUE/FIN/OUT; five words
        push(32'h10, 32'h11, 32'h12, 32'h13, 1'b0, 5'd0, 1'b0);
        push(32'h14, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
        for (int i = 0; i < 5; i++)
            send(32'h10 + 32'(i), i == 4);
        src_last = 1'b0;
        src_d    = 32'hDEAD_BEEF;
        wait_stream();
        chk("held_valid_ready_in_fill", {31'b0, src_ready}, 32'h1);
        idle();

        // last on a word filling slot 3: one issue, remainder 0
        push(32'h21, 32'h22, 32'h23, 32'h24, 1'b1, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            send(32'h21 + 32'(i), i == 3);
        idle();
        wait_stream();

        // reset mid-batch discards partial data
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        idle();
        rst = 1'b1;
        exp_rand = 32'h1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_data_1", core_data_1, 32'h0);
        chk("midrst_core_data_2", core_data_2, 32'h0);
        chk("midrst_tmp_rand", tmp_rand, 32'h1);
        repeat (4) @(negedge clk);
        push(32'h41, 32'h42, 32'h43, 32'h44, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            send(32'h41 + 32'(i), 1'b0);
        idle();
        repeat (6) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
